// File: rtl/dram_axi_ctrl_if.sv
// AXI4 read/write channel bundle between the bridge (master) and the DRAM controller (slave).
// Response codes are not carried; the top level ties RRESP/BRESP to OKAY.
interface dram_axi_ctrl_if #(
  parameter int ID_W = 8
);
  logic [ID_W-1:0] ARID;
  logic [31:0]     ARADDR;
  logic [3:0]      ARLEN;
  logic            ARVALID;
  logic            ARREADY;
  logic [ID_W-1:0] RID;
  logic [31:0]     RDATA;
  logic            RLAST;
  logic            RVALID;
  logic            RREADY;
  logic [ID_W-1:0] AWID;
  logic [31:0]     AWADDR;
  logic [3:0]      AWLEN;
  logic            AWVALID;
  logic            AWREADY;
  logic [31:0]     WDATA;
  logic [3:0]      WSTRB;
  logic            WLAST;
  logic            WVALID;
  logic            WREADY;
  logic [ID_W-1:0] BID;
  logic            BVALID;
  logic            BREADY;

  modport slave (
    input  ARID, ARADDR, ARLEN, ARVALID, RREADY,
    input  AWID, AWADDR, AWLEN, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    output ARREADY, RID, RDATA, RLAST, RVALID,
    output AWREADY, WREADY, BID, BVALID
  );

  modport master (
    output ARID, ARADDR, ARLEN, ARVALID, RREADY,
    output AWID, AWADDR, AWLEN, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    input  ARREADY, RID, RDATA, RLAST, RVALID,
    input  AWREADY, WREADY, BID, BVALID
  );
endinterface

// File: rtl/dram_axi_ctrl.sv
// AXI4 slave driving an SDRAM-style command interface: INCR bursts, open-page row reuse,
// a one-entry read buffer for R backpressure, and held write responses.
module dram_axi_ctrl #(
  parameter int ID_W      = 8,
  parameter int ROW_W     = 11,
  parameter int T_CMD     = 5,
  parameter int OPEN_PAGE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dram_axi_ctrl_if.slave       axi,
  input  logic [31:0]          DRAM_Q,
  input  logic                 DRAM_valid,
  output logic                 DRAM_CSn,
  output logic [3:0]           DRAM_WEn,
  output logic                 DRAM_RASn,
  output logic                 DRAM_CASn,
  output logic [10:0]          DRAM_A,
  output logic [31:0]          DRAM_D
);

  localparam int STEP_W = (T_CMD > 2) ? $clog2(T_CMD) : 1;
  localparam logic [STEP_W-1:0] STEP_FIRE = STEP_W'(T_CMD - 1);

  typedef enum logic [2:0] {S_IDLE, S_ACT, S_RD, S_WR, S_PRE, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               is_wr_q, is_wr_d;
  logic               pending_q, pending_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ROW_W-1:0]   open_row_q, open_row_d;
  logic               row_open_q, row_open_d;
  logic [9:0]         col_q, col_d;
  logic [3:0]         len_q, len_d;
  logic [3:0]         beat_q, beat_d;
  logic               rd_wait_q, rd_wait_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rlast_q, rlast_d;
  logic [ID_W-1:0]    rid_q, rid_d;
  logic [ID_W-1:0]    bid_q, bid_d;

  logic               fire;
  logic [9:0]         cas_col;
  logic [31:0]        req_addr;
  logic [ROW_W-1:0]   req_row;
  logic               unused_addr;
  logic               aw_ready, ar_ready, w_ready;
  logic               ras_n, cas_n;
  logic [3:0]         we_n;
  logic [10:0]        a_pin;

  assign fire     = (step_q == STEP_FIRE);
  assign cas_col  = col_q + 10'(beat_q);
  // AW has priority, so the address presented to the row compare follows AWVALID.
  assign req_addr = axi.AWVALID ? axi.AWADDR : axi.ARADDR;
  assign req_row  = req_addr[ROW_W+11:12];
  assign unused_addr = ^{req_addr[31:ROW_W+12], req_addr[1:0]};

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    is_wr_d    = is_wr_q;
    pending_d  = pending_q;
    row_d      = row_q;
    open_row_d = open_row_q;
    row_open_d = row_open_q;
    col_d      = col_q;
    len_d      = len_q;
    beat_d     = beat_q;
    rd_wait_d  = rd_wait_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rlast_d    = rlast_q;
    rid_d      = rid_q;
    bid_d      = bid_q;
    aw_ready   = 1'b0;
    ar_ready   = 1'b0;
    w_ready    = 1'b0;
    ras_n      = 1'b1;
    cas_n      = 1'b1;
    we_n       = 4'hF;
    a_pin      = '0;

    case (state_q)
      S_IDLE: begin
        aw_ready = 1'b1;
        ar_ready = !axi.AWVALID;
        if (axi.AWVALID || axi.ARVALID) begin
          is_wr_d   = axi.AWVALID;
          pending_d = 1'b1;
          row_d     = req_row;
          col_d     = req_addr[11:2];
          len_d     = axi.AWVALID ? axi.AWLEN : axi.ARLEN;
          beat_d    = '0;
          if (axi.AWVALID) bid_d = axi.AWID;
          else             rid_d = axi.ARID;
          if (row_open_q && (req_row == open_row_q))
            state_d = axi.AWVALID ? S_WR : S_RD;
          else if (row_open_q)
            state_d = S_PRE;
          else
            state_d = S_ACT;
        end
      end

      S_ACT: begin
        if (fire) begin
          ras_n      = 1'b0;
          a_pin      = 11'(row_q);
          row_open_d = 1'b1;
          open_row_d = row_q;
          state_d    = is_wr_q ? S_WR : S_RD;
        end
      end

      S_PRE: begin
        if (fire) begin
          ras_n      = 1'b0;
          we_n       = 4'h0;
          a_pin      = 11'(open_row_q);
          row_open_d = 1'b0;
          state_d    = pending_q ? S_ACT : S_IDLE;
        end
      end

      S_RD: begin
        // One beat in flight at a time: the next CAS waits for data and an empty buffer.
        if (fire && !rd_wait_q && !rvalid_q) begin
          cas_n     = 1'b0;
          a_pin     = {1'b0, cas_col};
          rd_wait_d = 1'b1;
        end
        if (rd_wait_q && DRAM_valid) begin
          rd_wait_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = DRAM_Q;
          rlast_d   = (beat_q == len_q);
        end
        if (rvalid_q && axi.RREADY) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            rlast_d   = 1'b0;
            pending_d = 1'b0;
            state_d   = (OPEN_PAGE != 0) ? S_IDLE : S_PRE;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end

      S_WR: begin
        if (fire) begin
          w_ready = 1'b1;
          if (axi.WVALID) begin
            cas_n  = 1'b0;
            we_n   = axi.WSTRB;
            a_pin  = {1'b0, cas_col};
            beat_d = beat_q + 4'd1;
            if ((beat_q == len_q) || axi.WLAST) state_d = S_RESP;
          end
        end
      end

      S_RESP: begin
        if (axi.BREADY) begin
          pending_d = 1'b0;
          state_d   = (OPEN_PAGE != 0) ? S_IDLE : S_PRE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Step counter restarts on entry and then sits at the fire value until the state moves on.
    if (state_d != state_q) step_d = '0;
    else if (!fire)         step_d = step_q + STEP_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      is_wr_q    <= 1'b0;
      pending_q  <= 1'b0;
      row_q      <= '0;
      open_row_q <= '0;
      row_open_q <= 1'b0;
      col_q      <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      rd_wait_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      bid_q      <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      is_wr_q    <= is_wr_d;
      pending_q  <= pending_d;
      row_q      <= row_d;
      open_row_q <= open_row_d;
      row_open_q <= row_open_d;
      col_q      <= col_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      rd_wait_q  <= rd_wait_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rlast_q    <= rlast_d;
      rid_q      <= rid_d;
      bid_q      <= bid_d;
    end
  end

  assign axi.AWREADY = aw_ready;
  assign axi.ARREADY = ar_ready;
  assign axi.WREADY  = w_ready;
  assign axi.RVALID  = rvalid_q;
  assign axi.RDATA   = rdata_q;
  assign axi.RLAST   = rlast_q;
  assign axi.RID     = rid_q;
  assign axi.BVALID  = (state_q == S_RESP);
  assign axi.BID     = bid_q;

  assign DRAM_CSn  = 1'b0;
  assign DRAM_RASn = ras_n;
  assign DRAM_CASn = cas_n;
  assign DRAM_WEn  = we_n;
  assign DRAM_A    = a_pin;
  assign DRAM_D    = axi.WDATA;

endmodule

// File: tb/tb_dram_axi_ctrl.sv
// Bench for dram_axi_ctrl: a pin-level DRAM model answers the controller, while an
// address-level reference memory and open-page model predict AXI data and command counts.
module tb_dram_axi_ctrl;

  localparam int T_CMD = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] DRAM_Q = '0;
  logic        DRAM_valid = 1'b0;
  logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
  logic [3:0]  DRAM_WEn;
  logic [10:0] DRAM_A;
  logic [31:0] DRAM_D;

  int vectors = 0;
  int miscompares = 0;

  dram_axi_ctrl_if #(.ID_W(8)) bus ();

  dram_axi_ctrl #(.ID_W(8), .ROW_W(11), .T_CMD(T_CMD), .OPEN_PAGE(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .axi        (bus),
    .DRAM_Q     (DRAM_Q),
    .DRAM_valid (DRAM_valid),
    .DRAM_CSn   (DRAM_CSn),
    .DRAM_WEn   (DRAM_WEn),
    .DRAM_RASn  (DRAM_RASn),
    .DRAM_CASn  (DRAM_CASn),
    .DRAM_A     (DRAM_A),
    .DRAM_D     (DRAM_D)
  );

  always #5 clk = ~clk;

  // Unwritten locations hold a fixed pattern known to both memories.
  function automatic logic [31:0] init_word(input int key);
    return (32'(key) * 32'h9E37_79B1) + 32'h1234_5678;
  endfunction

  // ---------------- pin-level DRAM model ----------------
  logic [31:0] dmem [int];
  int act_cnt = 0, pre_cnt = 0, cas_cnt = 0, cyc = 0, act_cyc = 0, cas_cyc = 0;
  int rd_dly = 0, rd_key = 0;
  logic [10:0] dram_row = '0, last_act_a = '0, last_pre_a = '0, last_cas_a = '0;
  logic [3:0]  last_wen = 4'hF;

  initial forever begin
    @(negedge clk);
    cyc++;
    DRAM_valid = 1'b0;
    if (rd_dly > 0) begin
      rd_dly--;
      if (rd_dly == 0) begin
        DRAM_valid = 1'b1;
        DRAM_Q = dmem.exists(rd_key) ? dmem[rd_key] : init_word(rd_key);
      end
    end
    if (!DRAM_RASn && DRAM_CASn) begin
      if (DRAM_WEn == 4'h0) begin
        pre_cnt++;
        last_pre_a = DRAM_A;
      end else begin
        act_cnt++;
        last_act_a = DRAM_A;
        dram_row = DRAM_A;
        act_cyc = cyc;
      end
    end
    if (!DRAM_CASn && DRAM_RASn) begin
      int key;
      logic [31:0] w;
      cas_cnt++;
      cas_cyc = cyc;
      last_cas_a = DRAM_A;
      key = int'(dram_row) * 1024 + int'(DRAM_A[9:0]);
      if (DRAM_WEn == 4'hF) begin
        rd_dly = $urandom_range(1, 3);
        rd_key = key;
      end else begin
        w = dmem.exists(key) ? dmem[key] : init_word(key);
        for (int i = 0; i < 4; i++) if (!DRAM_WEn[i]) w[i*8 +: 8] = DRAM_D[i*8 +: 8];
        dmem[key] = w;
        last_wen = DRAM_WEn;
      end
    end
  end

  // ---------------- reference model (AXI address space) ----------------
  logic [31:0] rmem [int];
  bit ref_open = 0;
  int ref_row = 0;

  function automatic int addr_key(input logic [31:0] addr, input int beat);
    return int'(addr[22:12]) * 1024 + ((int'(addr[11:2]) + beat) % 1024);
  endfunction

  function automatic logic [31:0] ref_rd(input int key);
    return rmem.exists(key) ? rmem[key] : init_word(key);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Predict row commands for a transaction and check them once it has finished.
  task automatic check_rows(input string tag, input int row, input int act0, input int pre0);
    int exp_act, exp_pre;
    exp_act = (ref_open && ref_row == row) ? 0 : 1;
    exp_pre = (ref_open && ref_row != row) ? 1 : 0;
    chk({tag, "_act_cnt"}, 32'(act_cnt - act0), 32'(exp_act));
    chk({tag, "_pre_cnt"}, 32'(pre_cnt - pre0), 32'(exp_pre));
    if (exp_act == 1) chk({tag, "_act_a"}, 32'(last_act_a), 32'(row));
    if (exp_pre == 1) chk({tag, "_pre_a"}, 32'(last_pre_a), 32'(ref_row));
    ref_open = 1;
    ref_row  = row;
  endtask

  task automatic axi_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input int stall_beat, input int stall_cyc);
    int act0, pre0, cas0, c;
    logic [31:0] hold;
    act0 = act_cnt; pre0 = pre_cnt; cas0 = cas_cnt;
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARVALID = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 500 && !bus.ARREADY; t++) @(negedge clk);
    chk("ar_ready", 32'(bus.ARREADY), 32'd1);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      @(negedge clk);
      for (int t = 0; t < 500 && !bus.RVALID; t++) @(negedge clk);
      chk("r_valid", 32'(bus.RVALID), 32'd1);
      chk("r_data", bus.RDATA, ref_rd(addr_key(addr, b)));
      chk("r_last", 32'(bus.RLAST), 32'(b == int'(len)));
      chk("r_id", 32'(bus.RID), 32'(id));
      $display("read  id=%02h addr=%08h beat=%0d data=%08h last=%0b", id, addr, b, bus.RDATA, bus.RLAST);
      if (b == stall_beat && stall_cyc > 0) begin
        hold = bus.RDATA;
        c = cas_cnt;
        repeat (stall_cyc) begin
          @(negedge clk);
          chk("r_hold_data", bus.RDATA, hold);
          chk("r_hold_valid", 32'(bus.RVALID), 32'd1);
        end
        chk("r_stall_no_cas", 32'(cas_cnt), 32'(c));
      end
      @(posedge clk); #1;
      bus.RREADY = 1'b1;
      @(posedge clk); #1;
      bus.RREADY = 1'b0;
    end
    chk("r_cas_cnt", 32'(cas_cnt - cas0), 32'(int'(len) + 1));
    check_rows("rd", int'(addr[22:12]), act0, pre0);
  endtask

  task automatic axi_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [3:0] strb_in, input int wdly, input int bstall);
    int act0, pre0, cas0, key;
    logic [3:0] strb;
    logic [31:0] data, w;
    act0 = act_cnt; pre0 = pre_cnt; cas0 = cas_cnt;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWVALID = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 500 && !bus.AWREADY; t++) @(negedge clk);
    chk("aw_ready", 32'(bus.AWREADY), 32'd1);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      repeat (wdly) begin @(posedge clk); #1; end
      chk("w_cas_gated", 32'(cas_cnt - cas0), 32'(b));
      strb = (strb_in == 4'hF) ? 4'($urandom_range(0, 14)) : strb_in;
      data = $urandom;
      bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = (b == int'(len)); bus.WVALID = 1'b1;
      @(negedge clk);
      for (int t = 0; t < 500 && !bus.WREADY; t++) @(negedge clk);
      chk("w_ready", 32'(bus.WREADY), 32'd1);
      @(posedge clk); #1;
      bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.WSTRB = 4'hF;
      key = addr_key(addr, b);
      w = ref_rd(key);
      for (int i = 0; i < 4; i++) if (!strb[i]) w[i*8 +: 8] = data[i*8 +: 8];
      rmem[key] = w;
      chk("w_wen", 32'(last_wen), 32'(strb));
      $display("write id=%02h addr=%08h beat=%0d data=%08h strb=%04b", id, addr, b, data, strb);
    end
    @(negedge clk);
    for (int t = 0; t < 500 && !bus.BVALID; t++) @(negedge clk);
    chk("b_valid", 32'(bus.BVALID), 32'd1);
    chk("b_id", 32'(bus.BID), 32'(id));
    repeat (bstall) begin
      @(negedge clk);
      chk("b_hold", 32'(bus.BVALID), 32'd1);
    end
    @(posedge clk); #1;
    bus.BREADY = 1'b1;
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
    chk("w_cas_cnt", 32'(cas_cnt - cas0), 32'(int'(len) + 1));
    check_rows("wr", int'(addr[22:12]), act0, pre0);
  endtask

  task automatic chk_pins_idle(input string tag);
    chk({tag, "_rasn"}, 32'(DRAM_RASn), 32'd1);
    chk({tag, "_casn"}, 32'(DRAM_CASn), 32'd1);
    chk({tag, "_wen"}, 32'(DRAM_WEn), 32'hF);
    chk({tag, "_a"}, 32'(DRAM_A), 32'd0);
    chk({tag, "_csn"}, 32'(DRAM_CSn), 32'd0);
  endtask

  initial begin
    logic [31:0] addr;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = 4'hF; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rvalid", 32'(bus.RVALID), 32'd0);
    chk("rst_bvalid", 32'(bus.BVALID), 32'd0);
    chk("rst_wready", 32'(bus.WREADY), 32'd0);
    chk("rst_rlast", 32'(bus.RLAST), 32'd0);
    chk("rst_rid", 32'(bus.RID), 32'd0);
    chk("rst_bid", 32'(bus.BID), 32'd0);
    chk_pins_idle("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single read from a closed row: ACT row 3, CAS col 2 T_CMD cycles later
    axi_read(8'h11, 32'h0000_3008, 4'd0, -1, 0);
    chk("t1_act_a", 32'(last_act_a), 32'h003);
    chk("t1_cas_a", 32'(last_cas_a), 32'h002);
    chk("t1_act_to_cas", 32'(cas_cyc - act_cyc), 32'(T_CMD));

    // 4-beat read, R stalled 3 cycles on beat 1
    axi_read(8'h22, 32'h0000_1000, 4'd3, 1, 3);
    chk("t2_last_col", 32'(last_cas_a), 32'h003);

    // 2-beat write with fixed strobes and delayed WVALID, then read it back
    axi_write(8'h5A, 32'h0000_2004, 4'd1, 4'b1100, 2, 2);
    axi_read(8'h33, 32'h0000_2004, 4'd1, -1, 0);

    // Open-page hits and a miss
    axi_read(8'h41, 32'h0000_5000, 4'd0, -1, 0);
    axi_read(8'h42, 32'h0000_5010, 4'd1, -1, 0);
    axi_read(8'h43, 32'h0000_9000, 4'd0, -1, 0);
    chk("t4_act_row9", 32'(last_act_a), 32'h009);

    // AW and AR together: write first, read after the response
    bus.ARID = 8'h77; bus.ARADDR = 32'h0000_9040; bus.ARLEN = 4'd0; bus.ARVALID = 1'b1;
    bus.AWID = 8'h66; bus.AWADDR = 32'h0000_9040; bus.AWLEN = 4'd0; bus.AWVALID = 1'b1;
    #1;
    chk("t5_awready", 32'(bus.AWREADY), 32'd1);
    chk("t5_arready", 32'(bus.ARREADY), 32'd0);
    axi_write(8'h66, 32'h0000_9040, 4'd0, 4'b0000, 0, 0);
    axi_read(8'h77, 32'h0000_9040, 4'd0, -1, 0);

    // Reset in the middle of a write burst
    bus.AWID = 8'h99; bus.AWADDR = 32'h0000_9000; bus.AWLEN = 4'd3; bus.AWVALID = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 500 && !bus.AWREADY; t++) @(negedge clk);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    @(negedge clk);
    for (int t = 0; t < 500 && !bus.WREADY; t++) @(negedge clk);
    chk("t6_wready_before", 32'(bus.WREADY), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_wready", 32'(bus.WREADY), 32'd0);
    chk("t6_bvalid", 32'(bus.BVALID), 32'd0);
    chk("t6_bid", 32'(bus.BID), 32'd0);
    chk_pins_idle("t6");
    $display("reset asserted mid write burst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    ref_open = 0;
    axi_read(8'h12, 32'h0000_9008, 4'd0, -1, 0);

    // Randomised mix of reads and writes
    for (int n = 0; n < 24; n++) begin
      int rsel;
      rsel = $urandom_range(0, 3);
      addr = $urandom;
      addr[31:23] = '0;
      if (rsel == 0) addr[22:12] = 11'd5;
      else if (rsel == 1) addr[22:12] = 11'd9;
      if ($urandom_range(0, 3) == 0) addr[11:2] = 10'(1020 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        axi_write(8'($urandom), addr, 4'($urandom_range(0, 7)), 4'hF,
                  $urandom_range(0, 2), $urandom_range(0, 2));
      else
        axi_read(8'($urandom), addr, 4'($urandom_range(0, 7)),
                 $urandom_range(0, 7), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
